fpu_norm_round_pipe: RTL
========================

FPU_NORM_ROUND_PIPE -- requirements
Module: fpu_norm_round_pipe

Interface
REQ-001 SHALL have parameter MAN_W, default 24, meaning mantissa width including the hidden bit.
REQ-002 SHALL have parameter EXP_W, default 8, meaning biased exponent width.
REQ-003 SHALL have parameter RND_MODE, default RNE, meaning rounding mode: RNE (round to nearest, ties to even) or RTZ (truncate).
REQ-004 SHALL have port i_clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 SHALL have port i_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port i_valid, input, 1 bit: input beat valid.
REQ-007 SHALL have port o_ready, output, 1 bit: block accepts an input beat this cycle.
REQ-008 SHALL have port i_sign, input, 1 bit: product sign.
REQ-009 SHALL have port i_zero_flag, input, 1 bit: the product is exactly zero.
REQ-010 SHALL have port i_exponent, input, EXP_W+2 bits, signed: biased exponent before normalisation.
REQ-011 SHALL have port i_mantissa, input, MAN_W+3 bits, laid out as follows: bit MAN_W+2 is the overflow bit, bits MAN_W+1 down to 2 are the mantissa with hidden bit at MAN_W+1, bit 1 is the guard bit, bit 0 is the sticky bit.
REQ-012 SHALL have port o_valid, output, 1 bit: result valid.
REQ-013 SHALL have port i_ready, input, 1 bit: downstream accepts the result.
REQ-014 SHALL have port o_sign, output, 1 bit: result sign.
REQ-015 SHALL have port o_exponent, output, EXP_W bits: result biased exponent.
REQ-016 SHALL have port o_mantissa, output, MAN_W bits: normalised mantissa with the hidden bit at the top.
REQ-017 SHALL have port o_ovf, output, 1 bit: result saturated to infinity.
REQ-018 SHALL have port o_unf, output, 1 bit: result flushed to zero.

Function
REQ-019 SHALL be a two-stage pipeline: S1 performs leading-one detection and normalising shift; S2 performs rounding, exponent adjustment, saturation/flush and drives the output register.
REQ-020 SHALL use a common advance enable en = ~o_valid | i_ready, with o_ready = en; a beat is accepted when i_valid & o_ready.
REQ-021 SHALL have a latency of 2 cycles from acceptance to o_valid when not stalled, and throughput of one beat per cycle.
REQ-022 SHALL hold all outputs and stage registers stable while o_valid & ~i_ready.
REQ-023 SHALL, in S1, when the overflow bit is set, shift the mantissa right by 1 (the shifted-out bit becomes guard, old guard|sticky becomes sticky) and add 1 to the exponent.
REQ-024 SHALL, in S1, when the overflow bit is clear, compute lz = leading zeros of bits MAN_W+1..0, shift left by lz (guard/sticky included, zero-filled) and subtract lz from the exponent.
REQ-025 SHALL, in S2 with RNE, increment the mantissa when guard & (sticky | lsb); RTZ never increments.
REQ-026 SHALL, in S2, when the rounding increment carries out of MAN_W bits, set the mantissa to 1000...0 and add 1 to the exponent.
REQ-027 SHALL, when the final exponent >= 2^EXP_W-1, output exponent all ones, mantissa 0, and o_ovf=1.
REQ-028 SHALL, when the final exponent <= 0, output exponent 0, mantissa 0, and o_unf=1; no denormals are produced.
REQ-029 SHALL, when i_zero_flag=1 or the mantissa field is all zero, output mantissa 0, exponent 0, o_ovf=0 and o_unf=0, with o_sign equal to i_sign.
REQ-030 SHALL assert o_ovf and o_unf only while o_valid=1, and never both together.

Reset
REQ-031 SHALL, while i_rst_n=0, immediately clear o_valid, both stage-valid bits, o_sign, o_exponent, o_mantissa, o_ovf and o_unf to 0.
REQ-032 SHALL discard in-flight beats on reset mid-operation, and have o_ready=1 in the first cycle after deassertion.

Structure
REQ-033 SHALL take the rounding-mode enum (RNE, RTZ) and the default MAN_W/EXP_W constants from the shared package fpu_pkg.
REQ-034 SHALL contain one sub-module, norm_lzc (parametrised leading-zero counter, output width $clog2(MAN_W+3)).

Verification
REQ-035 SHALL cover: exponent 130, mantissa field 0x800000, no overflow, G=S=0 -> after 2 cycles exponent 130, mantissa 0x800000, no flags.
REQ-036 SHALL cover: overflow bit set, exponent 127 -> exponent 128, mantissa shifted right by 1, RNE applied to the dropped bit.
REQ-037 SHALL cover: mantissa field 0xFFFFFF with G=1, S=1, exponent 100 under RNE -> exponent 101, mantissa 0x800000; under RTZ -> exponent 100, mantissa 0xFFFFFF.
REQ-038 SHALL cover: exponent 260 -> exponent 0xFF, mantissa 0, o_ovf=1; exponent 3 with lz=5 -> all zero, o_unf=1.
REQ-039 SHALL cover: i_ready held low for 4 cycles with 3 beats offered -> o_ready drops, outputs stable, no beat lost or duplicated, in-order release.
REQ-040 SHALL cover: i_rst_n pulsed low with 2 beats in flight -> o_valid=0 immediately, no stale result emitted after release.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared floating-point definitions: rounding modes and default format widths.
package fpu_pkg;

    typedef enum logic {
        RNE = 1'b0,
        RTZ = 1'b1
    } rnd_mode_e;

    localparam int MAN_W_DEF = 24;
    localparam int EXP_W_DEF = 8;

endpackage

// File: rtl/norm_lzc.sv
// Leading-zero counter; an all-zero input reports W.
module norm_lzc #(
    parameter int W  = 26,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  i_vec,
    output logic [CW-1:0] o_count
);

    // Scanning upward lets the highest set bit write last and win.
    always_comb begin
        o_count = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (i_vec[i]) begin
                o_count = CW'(W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fpu_norm_round_pipe.sv
// Two-stage normalise/round back end of a floating-point multiplier:
// S1 normalises the raw product, S2 rounds, saturates or flushes into the output register.
module fpu_norm_round_pipe
    import fpu_pkg::*;
#(
    parameter int        MAN_W    = MAN_W_DEF,
    parameter int        EXP_W    = EXP_W_DEF,
    parameter rnd_mode_e RND_MODE = RNE
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic                    i_sign,
    input  logic                    i_zero_flag,
    input  logic signed [EXP_W+1:0] i_exponent,
    input  logic [MAN_W+2:0]        i_mantissa,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic                    o_sign,
    output logic [EXP_W-1:0]        o_exponent,
    output logic [MAN_W-1:0]        o_mantissa,
    output logic                    o_ovf,
    output logic                    o_unf
);

    localparam int XW   = EXP_W + 3;
    localparam int LZ_W = $clog2(MAN_W + 3);

    localparam logic signed [XW-1:0] ONE_X   = 1;
    localparam logic signed [XW-1:0] ZERO_X  = 0;
    localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);

    // Handshake: a beat transfers on a rising edge where valid & ready are both high.
    // Both stages advance together on en; bubbles move through like beats, and
    // everything holds while a result sits unconsumed at the output.
    logic en;
    assign en      = ~o_valid | i_ready;
    assign o_ready = en;

    logic [LZ_W-1:0]        lz;
    logic [MAN_W+1:0]       shl;
    logic signed [XW-1:0]   exp_in;
    logic                   n1_zero;
    logic [MAN_W-1:0]       n1_man;
    logic                   n1_guard;
    logic                   n1_sticky;
    logic signed [XW-1:0]   n1_exp;

    norm_lzc #(
        .W  (MAN_W + 2),
        .CW (LZ_W)
    ) u_lzc (
        .i_vec   (i_mantissa[MAN_W+1:0]),
        .o_count (lz)
    );

    assign exp_in = $signed({i_exponent[EXP_W+1], i_exponent});
    assign shl    = i_mantissa[MAN_W+1:0] << lz;

    always_comb begin
        n1_zero = i_zero_flag | (i_mantissa[MAN_W+2:2] == '0);
        if (i_mantissa[MAN_W+2]) begin
            n1_man    = i_mantissa[MAN_W+2:3];
            n1_guard  = i_mantissa[2];
            n1_sticky = |i_mantissa[1:0];
            n1_exp    = exp_in + ONE_X;
        end else begin
            n1_man    = shl[MAN_W+1:2];
            n1_guard  = shl[1];
            n1_sticky = shl[0];
            n1_exp    = exp_in - $signed({{(XW-LZ_W){1'b0}}, lz});
        end
    end

    logic                   s1_valid;
    logic                   s1_sign;
    logic                   s1_zero;
    logic [MAN_W-1:0]       s1_man;
    logic                   s1_guard;
    logic                   s1_sticky;
    logic signed [XW-1:0]   s1_exp;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid  <= 1'b0;
            s1_sign   <= 1'b0;
            s1_zero   <= 1'b0;
            s1_man    <= '0;
            s1_guard  <= 1'b0;
            s1_sticky <= 1'b0;
            s1_exp    <= '0;
        end else if (en) begin
            s1_valid  <= i_valid;
            s1_sign   <= i_sign;
            s1_zero   <= n1_zero;
            s1_man    <= n1_man;
            s1_guard  <= n1_guard;
            s1_sticky <= n1_sticky;
            s1_exp    <= n1_exp;
        end
    end

    logic                   round_up;
    logic [MAN_W:0]         sum;
    logic [MAN_W-1:0]       r_man;
    logic signed [XW-1:0]   r_exp;
    logic [EXP_W-1:0]       n2_exp;
    logic [MAN_W-1:0]       n2_man;
    logic                   n2_ovf;
    logic                   n2_unf;

    always_comb begin
        round_up = (RND_MODE == RNE) & s1_guard & (s1_sticky | s1_man[0]);
        sum      = {1'b0, s1_man} + {{MAN_W{1'b0}}, round_up};
        if (sum[MAN_W]) begin
            r_man = {1'b1, {(MAN_W-1){1'b0}}};
            r_exp = s1_exp + ONE_X;
        end else begin
            r_man = sum[MAN_W-1:0];
            r_exp = s1_exp;
        end

        n2_exp = '0;
        n2_man = '0;
        n2_ovf = 1'b0;
        n2_unf = 1'b0;
        if (s1_zero) begin
            n2_exp = '0;
        end else if (r_exp >= EXP_MAX) begin
            n2_exp = '1;
            n2_ovf = 1'b1;
        end else if (r_exp <= ZERO_X) begin
            n2_unf = 1'b1;
        end else begin
            n2_exp = r_exp[EXP_W-1:0];
            n2_man = r_man;
        end
    end

    // Flags are qualified by the stage valid so a bubble never raises them.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid    <= 1'b0;
            o_sign     <= 1'b0;
            o_exponent <= '0;
            o_mantissa <= '0;
            o_ovf      <= 1'b0;
            o_unf      <= 1'b0;
        end else if (en) begin
            o_valid    <= s1_valid;
            o_sign     <= s1_sign;
            o_exponent <= n2_exp;
            o_mantissa <= n2_man;
            o_ovf      <= s1_valid & n2_ovf;
            o_unf      <= s1_valid & n2_unf;
        end
    end

endmodule
